// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU: opcodes, FSM encoding and
// the combinational result of the eight single-cycle operations.
package alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_SLL  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_AND  = 4'd4;
   localparam logic [3:0] OP_SLTU = 4'd5;
   localparam logic [3:0] OP_SLT  = 4'd6;
   localparam logic [3:0] OP_NOR  = 4'd7;
   localparam logic [3:0] OP_MULU = 4'd8;
   localparam logic [3:0] OP_DIVU = 4'd9;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Operands arrive sign-extended to 64 bits, which keeps both the signed
   // and unsigned ordering of the narrower value; callers truncate the result.
   function automatic logic [63:0] alu_comb(input logic [3:0]  op,
                                            input logic [63:0] a,
                                            input logic [63:0] b,
                                            input logic [5:0]  sh);
      logic [63:0] r;
      r = '0;
      case (op)
         OP_ADD:  r = a + b;
         OP_SUB:  r = a - b;
         OP_SLL:  r = b << sh;
         OP_OR:   r = a | b;
         OP_AND:  r = a & b;
         OP_SLTU: r = {63'd0, (a < b)};
         OP_SLT:  r = {63'd0, ($signed(a) < $signed(b))};
         OP_NOR:  r = ~(a | b);
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/md_iter.sv
// Iterative unsigned multiply (shift-add) and restoring divide datapath.
// Exposes the next-step values so the owner can register the final step.
module md_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic             i_div,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_step,
   output logic [WIDTH-1:0] o_hi_nxt,
   output logic [WIDTH-1:0] o_lo_nxt,
   output logic             o_last
);

   localparam int CW = $clog2(WIDTH) + 1;

   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH-1:0] r_b;
   logic             r_div;
   logic [CW-1:0]    r_cnt;

   logic [WIDTH:0]   w_sum;
   logic             w_ge;
   logic [WIDTH-1:0] w_diff;
   logic [WIDTH-1:0] w_hi_nxt;
   logic [WIDTH-1:0] w_lo_nxt;

   // Divide: remainder shifts in the next dividend bit from lo; a zero
   // divisor always "fits", giving an all-ones quotient and remainder = A.
   always_comb begin
      w_sum    = '0;
      w_ge     = 1'b0;
      w_diff   = '0;
      w_hi_nxt = r_hi;
      w_lo_nxt = r_lo;
      if (r_div) begin
         w_ge   = ({r_hi, r_lo[WIDTH-1]} >= {1'b0, r_b});
         w_diff = WIDTH'({r_hi, r_lo[WIDTH-1]} - {1'b0, r_b});
         if (w_ge) begin
            w_hi_nxt = w_diff;
            w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
         end else begin
            w_hi_nxt = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
            w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
         end
      end else begin
         w_sum    = r_lo[0] ? ({1'b0, r_hi} + {1'b0, r_b}) : {1'b0, r_hi};
         w_hi_nxt = w_sum[WIDTH:1];
         w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_hi  <= '0;
         r_lo  <= '0;
         r_b   <= '0;
         r_div <= 1'b0;
         r_cnt <= '0;
      end else if (i_load) begin
         r_hi  <= '0;
         r_lo  <= i_a;
         r_b   <= i_b;
         r_div <= i_div;
         r_cnt <= CW'(WIDTH);
      end else if (i_step) begin
         r_hi  <= w_hi_nxt;
         r_lo  <= w_lo_nxt;
         r_cnt <= r_cnt - CW'(1);
      end
   end

   assign o_hi_nxt = w_hi_nxt;
   assign o_lo_nxt = w_lo_nxt;
   assign o_last   = (r_cnt == CW'(1));

endmodule

// File: rtl/seq_alu.sv
// Registered execute-stage ALU: single-cycle ops complete in one edge,
// MULU/DIVU run WIDTH steps behind a Start/Busy/Done handshake.
module seq_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             Start,
   input  logic [3:0]       ALUop,
   input  logic             ALUSrcA,
   input  logic             ALUSrcB,
   input  logic [WIDTH-1:0] ReadData1,
   input  logic [WIDTH-1:0] ReadData2,
   input  logic [WIDTH-1:0] Ext,
   input  logic [WIDTH-1:0] Sa,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Result,
   output logic [WIDTH-1:0] ResultHi,
   output logic             zero,
   output state_t           dbg_state
);

   // Handshake: Start is taken only in IDLE (Busy=0); Done pulses for one
   // cycle after the completing edge and Result/ResultHi/zero hold after it.

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_result;
   logic [WIDTH-1:0] r_result_hi;
   logic             r_zero;
   logic             r_done;

   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;
   logic [WIDTH-1:0] w_single;
   logic             w_is_md;
   logic             w_accept;
   logic             w_load;
   logic             w_step;
   logic             w_fin_sc;
   logic             w_fin_md;
   logic             w_busy;
   logic             w_last;
   logic [WIDTH-1:0] w_hi_nxt;
   logic [WIDTH-1:0] w_lo_nxt;

   assign w_a      = ALUSrcA ? Sa  : ReadData1;
   assign w_b      = ALUSrcB ? Ext : ReadData2;
   assign w_is_md  = (ALUop == OP_MULU) || (ALUop == OP_DIVU);
   assign w_accept = (r_state == ST_IDLE) && Start;
   assign w_single = WIDTH'(alu_comb(ALUop, 64'($signed(w_a)), 64'($signed(w_b)),
                                     6'(w_a[SHW-1:0])));

   always_ff @(posedge CLK) begin
      if (!Reset) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_accept && w_is_md) w_state_nxt = ST_RUN;
         ST_RUN:  if (w_last)              w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_load   = 1'b0;
      w_step   = 1'b0;
      w_fin_sc = 1'b0;
      w_fin_md = 1'b0;
      w_busy   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_load   = w_accept && w_is_md;
            w_fin_sc = w_accept && !w_is_md;
         end
         ST_RUN: begin
            w_busy   = 1'b1;
            w_step   = 1'b1;
            w_fin_md = w_last;
         end
         default: ;
      endcase
   end

   md_iter #(
      .WIDTH (WIDTH)
   ) u_md_iter (
      .clk      (CLK),
      .rst_n    (Reset),
      .i_load   (w_load),
      .i_div    (ALUop == OP_DIVU),
      .i_a      (w_a),
      .i_b      (w_b),
      .i_step   (w_step),
      .o_hi_nxt (w_hi_nxt),
      .o_lo_nxt (w_lo_nxt),
      .o_last   (w_last)
   );

   // Outputs move only on a completing edge; partial products stay inside md_iter.
   always_ff @(posedge CLK) begin
      if (!Reset) begin
         r_result    <= '0;
         r_result_hi <= '0;
         r_zero      <= 1'b1;
         r_done      <= 1'b0;
      end else begin
         r_done <= w_fin_sc || w_fin_md;
         if (w_fin_sc) begin
            r_result    <= w_single;
            r_result_hi <= '0;
            r_zero      <= (w_single == '0);
         end else if (w_fin_md) begin
            r_result    <= w_lo_nxt;
            r_result_hi <= w_hi_nxt;
            r_zero      <= (w_lo_nxt == '0);
         end
      end
   end

   assign Busy      = w_busy;
   assign Done      = r_done;
   assign Result    = r_result;
   assign ResultHi  = r_result_hi;
   assign zero      = r_zero;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=32): single-cycle ops, handshake,
// iterative multiply/divide latency and reset abort.
module tb_seq_alu;
   import alu_pkg::*;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [3:0]    op = 4'd0;
   logic          src_a = 1'b0;
   logic          src_b = 1'b0;
   logic [W-1:0]  rd1 = '0;
   logic [W-1:0]  rd2 = '0;
   logic [W-1:0]  ext = '0;
   logic [W-1:0]  sa = '0;
   logic          busy;
   logic          done;
   logic [W-1:0]  res;
   logic [W-1:0]  res_hi;
   logic          zero;
   state_t        dbg_state;

   int tests_run = 0;
   int tests_failed = 0;

   seq_alu #(.WIDTH(W)) dut (
      .CLK       (clk),
      .Reset     (rst_n),
      .Start     (start),
      .ALUop     (op),
      .ALUSrcA   (src_a),
      .ALUSrcB   (src_b),
      .ReadData1 (rd1),
      .ReadData2 (rd2),
      .Ext       (ext),
      .Sa        (sa),
      .Busy      (busy),
      .Done      (done),
      .Result    (res),
      .ResultHi  (res_hi),
      .zero      (zero),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Drive one request for a single edge; returns 1 time unit after that edge.
   task automatic issue(input logic [3:0] o, input logic sel_a, input logic sel_b,
                        input logic [W-1:0] a1, input logic [W-1:0] a2,
                        input logic [W-1:0] e, input logic [W-1:0] s);
      op = o; src_a = sel_a; src_b = sel_b;
      rd1 = a1; rd2 = a2; ext = e; sa = s;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Count cycles with Busy=1, bounded so a stuck FSM cannot hang the run.
   task automatic count_busy(output int n);
      n = 0;
      while (busy && n < 100) begin
         n++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
      tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", done); end
      tests_run++; if (res !== 32'h0) begin tests_failed++; $display("FAIL reset_result: got %h want 0", res); end
      tests_run++; if (res_hi !== 32'h0) begin tests_failed++; $display("FAIL reset_result_hi: got %h want 0", res_hi); end
      tests_run++; if (zero !== 1'b1) begin tests_failed++; $display("FAIL reset_zero: got %b want 1", zero); end
      tests_run++; if (dbg_state !== ST_IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_add;
      issue(OP_ADD, 1'b0, 1'b1, 32'd5, 32'd99, 32'd7, 32'd0);
      tests_run++; if (res !== 32'd12) begin tests_failed++; $display("FAIL add_result: got %h want %h", res, 32'd12); end
      tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL add_done: got %b want 1", done); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL add_busy: got %b want 0", busy); end
      tests_run++; if (res_hi !== 32'h0) begin tests_failed++; $display("FAIL add_hi: got %h want 0", res_hi); end
      tests_run++; if (zero !== 1'b0) begin tests_failed++; $display("FAIL add_zero: got %b want 0", zero); end
      @(posedge clk); #1;
      tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL add_done_pulse: got %b want 0", done); end
      tests_run++; if (res !== 32'd12) begin tests_failed++; $display("FAIL add_hold: got %h want %h", res, 32'd12); end
   endtask

   task automatic test_sub_sll;
      issue(OP_SUB, 1'b0, 1'b0, 32'd3, 32'd3, 32'd0, 32'd0);
      tests_run++; if (res !== 32'd0) begin tests_failed++; $display("FAIL sub_result: got %h want 0", res); end
      tests_run++; if (zero !== 1'b1) begin tests_failed++; $display("FAIL sub_zero: got %b want 1", zero); end
      issue(OP_SUB, 1'b0, 1'b0, 32'd3, 32'd5, 32'd0, 32'd0);
      tests_run++; if (res !== 32'hFFFF_FFFE) begin tests_failed++; $display("FAIL sub_wrap: got %h want fffffffe", res); end
      issue(OP_SLL, 1'b1, 1'b1, 32'd0, 32'd0, 32'd2, 32'd4);
      tests_run++; if (res !== 32'd32) begin tests_failed++; $display("FAIL sll_result: got %h want %h", res, 32'd32); end
      issue(OP_SLL, 1'b1, 1'b1, 32'd0, 32'd0, 32'd3, 32'd33);
      tests_run++; if (res !== 32'd6) begin tests_failed++; $display("FAIL sll_shamt_mask: got %h want 6", res); end
   endtask

   task automatic test_compare_logic;
      issue(OP_SLT, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
      tests_run++; if (res !== 32'd1) begin tests_failed++; $display("FAIL slt_result: got %h want 1", res); end
      issue(OP_SLTU, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
      tests_run++; if (res !== 32'd0) begin tests_failed++; $display("FAIL sltu_result: got %h want 0", res); end
      tests_run++; if (zero !== 1'b1) begin tests_failed++; $display("FAIL sltu_zero: got %b want 1", zero); end
      issue(OP_NOR, 1'b0, 1'b0, 32'd1, 32'd2, 32'd0, 32'd0);
      tests_run++; if (res !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL nor_result: got %h want fffffffc", res); end
      issue(OP_AND, 1'b0, 1'b0, 32'hF0F0_1234, 32'h0FF0_00FF, 32'd0, 32'd0);
      tests_run++; if (res !== 32'h00F0_0034) begin tests_failed++; $display("FAIL and_result: got %h want 00f00034", res); end
      issue(4'd12, 1'b0, 1'b0, 32'd9, 32'd9, 32'd0, 32'd0);
      tests_run++; if (res !== 32'd0 || zero !== 1'b1 || done !== 1'b1) begin tests_failed++; $display("FAIL undef_op: got res=%h zero=%b done=%b want 0/1/1", res, zero, done); end
   endtask

   task automatic test_back_to_back;
      src_a = 1'b0; src_b = 1'b0;
      start = 1'b1; op = OP_ADD; rd1 = 32'd1; rd2 = 32'd2;
      @(posedge clk); #1;
      tests_run++; if (done !== 1'b1 || res !== 32'd3) begin tests_failed++; $display("FAIL b2b_first: got done=%b res=%h want 1/3", done, res); end
      op = OP_OR; rd1 = 32'd8; rd2 = 32'd4;
      @(posedge clk); #1;
      tests_run++; if (done !== 1'b1 || res !== 32'd12) begin tests_failed++; $display("FAIL b2b_second: got done=%b res=%h want 1/c", done, res); end
      op = OP_AND; rd1 = 32'd6; rd2 = 32'd3;
      @(posedge clk); #1;
      tests_run++; if (done !== 1'b1 || res !== 32'd2) begin tests_failed++; $display("FAIL b2b_third: got done=%b res=%h want 1/2", done, res); end
      start = 1'b0;
      @(posedge clk); #1;
      tests_run++; if (done !== 1'b0 || res !== 32'd2) begin tests_failed++; $display("FAIL b2b_end: got done=%b res=%h want 0/2", done, res); end
   endtask

   task automatic test_mulu;
      int n;
      int held_bad;
      held_bad = 0;
      issue(OP_ADD, 1'b0, 1'b0, 32'd40, 32'd2, 32'd0, 32'd0);
      tests_run++; if (res !== 32'd42) begin tests_failed++; $display("FAIL mul_pre_add: got %h want 2a", res); end
      issue(OP_MULU, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0);
      n = 0;
      while (busy && n < 100) begin
         if (done !== 1'b0 || res !== 32'd42 || res_hi !== 32'd0) held_bad++;
         if (n == 9) begin
            start = 1'b1; op = OP_ADD; rd1 = 32'd0; rd2 = 32'd0;
         end else begin
            start = 1'b0;
         end
         n++;
         @(posedge clk); #1;
      end
      start = 1'b0;
      tests_run++; if (held_bad !== 0) begin tests_failed++; $display("FAIL mul_hold_during_run: got %0d bad cycles want 0", held_bad); end
      tests_run++; if (n !== 32) begin tests_failed++; $display("FAIL mul_busy_cycles: got %0d want 32", n); end
      tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL mul_done: got %b want 1", done); end
      tests_run++; if (res !== 32'hFFFF_FFFE) begin tests_failed++; $display("FAIL mul_lo: got %h want fffffffe", res); end
      tests_run++; if (res_hi !== 32'd1) begin tests_failed++; $display("FAIL mul_hi: got %h want 1", res_hi); end
      @(posedge clk); #1;
      tests_run++; if (done !== 1'b0 || busy !== 1'b0 || res !== 32'hFFFF_FFFE) begin tests_failed++; $display("FAIL mul_ignored_start: got done=%b busy=%b res=%h want 0/0/fffffffe", done, busy, res); end
   endtask

   task automatic test_divu;
      int n;
      issue(OP_DIVU, 1'b0, 1'b0, 32'd100, 32'd7, 32'd0, 32'd0);
      count_busy(n);
      tests_run++; if (n !== 32) begin tests_failed++; $display("FAIL div_busy_cycles: got %0d want 32", n); end
      tests_run++; if (done !== 1'b1 || res !== 32'd14 || res_hi !== 32'd2) begin tests_failed++; $display("FAIL div_100_7: got done=%b q=%h r=%h want 1/e/2", done, res, res_hi); end
      issue(OP_DIVU, 1'b0, 1'b0, 32'd9, 32'd0, 32'd0, 32'd0);
      count_busy(n);
      tests_run++; if (n !== 32) begin tests_failed++; $display("FAIL div0_busy_cycles: got %0d want 32", n); end
      tests_run++; if (done !== 1'b1 || res !== 32'hFFFF_FFFF || res_hi !== 32'd9) begin tests_failed++; $display("FAIL div_9_0: got done=%b q=%h r=%h want 1/ffffffff/9", done, res, res_hi); end
      tests_run++; if (zero !== 1'b0) begin tests_failed++; $display("FAIL div_9_0_zero: got %b want 0", zero); end
   endtask

   task automatic test_reset_abort;
      int dones;
      dones = 0;
      issue(OP_MULU, 1'b0, 1'b0, 32'd3, 32'd5, 32'd0, 32'd0);
      repeat (14) @(posedge clk);
      #1;
      tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL abort_busy_before: got %b want 1", busy); end
      rst_n = 1'b0;
      @(posedge clk); #1;
      tests_run++; if (busy !== 1'b0 || done !== 1'b0 || res !== 32'd0 || res_hi !== 32'd0 || zero !== 1'b1) begin
         tests_failed++; $display("FAIL abort_reset_state: got busy=%b done=%b res=%h hi=%h zero=%b want 0/0/0/0/1", busy, done, res, res_hi, zero);
      end
      rst_n = 1'b1;
      repeat (40) begin
         @(posedge clk); #1;
         if (done !== 1'b0) dones++;
      end
      tests_run++; if (dones !== 0) begin tests_failed++; $display("FAIL abort_no_done: got %0d done cycles want 0", dones); end
      issue(OP_ADD, 1'b0, 1'b1, 32'd1, 32'd0, 32'd1, 32'd0);
      tests_run++; if (done !== 1'b1 || res !== 32'd2) begin tests_failed++; $display("FAIL abort_then_add: got done=%b res=%h want 1/2", done, res); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub_sll();
      test_compare_logic();
      test_back_to_back();
      test_mulu();
      test_divu();
      test_reset_abort();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
